// File: rtl/irq_pc_sel_ctrl_if.sv
// Interrupt/PC-redirect bundle between the pipeline and the interrupt sequencer.
// The master side is the pipeline and interrupt sources. The slave side is the sequencer.
interface irq_pc_sel_ctrl_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [31:0]        pc_resume;
  logic               pipe_ok;
  logic               eret;
  logic               pc_sel;
  logic [31:0]        pc_redirect;
  logic               flush;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [31:0]        epc;
  logic [2:0]         cause;
  logic               in_isr;

  modport master (
    output irq_req, irq_mask, pc_resume, pipe_ok, eret,
    input  pc_sel, pc_redirect, flush, irq_ack, epc, cause, in_isr
  );

  modport slave (
    input  irq_req, irq_mask, pc_resume, pipe_ok, eret,
    output pc_sel, pc_redirect, flush, irq_ack, epc, cause, in_isr
  );
endinterface

// File: rtl/irq_pc_sel_ctrl.sv
// Interrupt sequencer that drives the PC-source mux.
// It waits for a safe pipeline point, redirects to the handler while saving EPC, and returns to EPC on ERET.
module irq_pc_sel_ctrl #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
  input logic              clk,
  input logic              rst_n,
  irq_pc_sel_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ENTER = 3'd2,
    S_ISR   = 3'd3,
    S_EXIT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        epc_q, epc_d;
  logic [2:0]         cause_q, cause_d;
  logic [31:0]        redirect_q, redirect_d;

  logic [NUM_IRQ-1:0] pend;
  logic               any_pend;
  logic [2:0]         win_idx;
  logic               found;

  assign pend     = bus.irq_req & bus.irq_mask;
  assign any_pend = |pend;

  // Fixed priority: the lowest index wins.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pend[i] && !found) begin
        win_idx = 3'(i);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      epc_q      <= '0;
      cause_q    <= '0;
      redirect_q <= HANDLER_ADDR;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      redirect_q <= redirect_d;
    end
  end

  // The redirect target is registered on the edge that enters ENTER/EXIT.
  // This keeps pc_redirect a pure state output that holds between redirects.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    redirect_d = redirect_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_pend) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!any_pend) begin
          state_d = S_IDLE;
        end else if (bus.pipe_ok) begin
          state_d    = S_ENTER;
          cause_d    = win_idx;
          epc_d      = bus.pc_resume;
          redirect_d = HANDLER_ADDR;
        end
      end
      S_ENTER: state_d = S_ISR;
      S_ISR: begin
        if (bus.eret) begin
          state_d    = S_EXIT;
          redirect_d = epc_q;
        end
      end
      S_EXIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_sel  = 1'b0;
    bus.flush   = 1'b0;
    bus.irq_ack = '0;
    bus.in_isr  = 1'b0;
    case (state_q)
      S_ENTER: begin
        bus.pc_sel  = 1'b1;
        bus.flush   = 1'b1;
        bus.irq_ack = NUM_IRQ'(1) << cause_q;
      end
      S_ISR:   bus.in_isr = 1'b1;
      S_EXIT: begin
        bus.pc_sel = 1'b1;
        bus.flush  = 1'b1;
        bus.in_isr = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_redirect = redirect_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;

endmodule

// File: tb/tb_irq_pc_sel_ctrl.sv
// Directed bench for irq_pc_sel_ctrl: entry/exit latency, priority, masking, stalls, ERET, no nesting and async reset.
module tb_irq_pc_sel_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  irq_pc_sel_ctrl_if #(.NUM_IRQ(4)) bus ();

  irq_pc_sel_ctrl #(
    .NUM_IRQ      (4),
    .HANDLER_ADDR (32'h0000_0004)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.irq_req   = '0;
    bus.irq_mask  = '0;
    bus.pc_resume = '0;
    bus.pipe_ok   = 1'b0;
    bus.eret      = 1'b0;
    #12;
    check("rst pc_sel",   32'(bus.pc_sel), 32'd0);
    check("rst flush",    32'(bus.flush), 32'd0);
    check("rst irq_ack",  32'(bus.irq_ack), 32'd0);
    check("rst in_isr",   32'(bus.in_isr), 32'd0);
    check("rst epc",      bus.epc, 32'd0);
    check("rst cause",    32'(bus.cause), 32'd0);
    check("rst redirect", bus.pc_redirect, 32'h4);
    rst_n = 1'b1;

    // T2: single irq on line 2
    bus.irq_req = 4'b0100; bus.irq_mask = 4'b1111; bus.pipe_ok = 1'b1; bus.pc_resume = 32'h40;
    tick();
    check("t2 wait pc_sel", 32'(bus.pc_sel), 32'd0);
    tick();
    check("t2 enter pc_sel",   32'(bus.pc_sel), 32'd1);
    check("t2 enter redirect", bus.pc_redirect, 32'h4);
    check("t2 enter flush",    32'(bus.flush), 32'd1);
    check("t2 enter ack",      32'(bus.irq_ack), 32'b0100);
    check("t2 enter in_isr",   32'(bus.in_isr), 32'd0);
    bus.irq_req = '0;
    tick();
    check("t2 isr pc_sel", 32'(bus.pc_sel), 32'd0);
    check("t2 isr ack",    32'(bus.irq_ack), 32'd0);
    check("t2 isr cause",  32'(bus.cause), 32'd2);
    check("t2 isr epc",    bus.epc, 32'h40);
    check("t2 isr in_isr", 32'(bus.in_isr), 32'd1);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("t2 exit pc_sel",   32'(bus.pc_sel), 32'd1);
    check("t2 exit redirect", bus.pc_redirect, 32'h40);
    check("t2 exit in_isr",   32'(bus.in_isr), 32'd1);
    tick();
    check("t2 idle in_isr",   32'(bus.in_isr), 32'd0);
    check("t2 idle redirect", bus.pc_redirect, 32'h40);

    // T3: priority with mask
    bus.irq_req = 4'b1011; bus.irq_mask = 4'b1110; bus.pc_resume = 32'h100;
    tick();
    tick();
    check("t3 cause", 32'(bus.cause), 32'd1);
    check("t3 ack",   32'(bus.irq_ack), 32'b0010);
    check("t3 epc",   bus.epc, 32'h100);
    bus.irq_req = '0;
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    tick();

    // T4: stall hold
    bus.irq_req = 4'b0001; bus.irq_mask = 4'b1111; bus.pipe_ok = 1'b0; bus.pc_resume = 32'h50;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4 stall pc_sel", 32'(bus.pc_sel), 32'd0);
    end
    bus.pipe_ok = 1'b1; bus.pc_resume = 32'h88;
    tick();
    check("t4 enter pc_sel", 32'(bus.pc_sel), 32'd1);
    check("t4 epc",          bus.epc, 32'h88);
    check("t4 cause",        32'(bus.cause), 32'd0);
    check("t4 ack",          32'(bus.irq_ack), 32'b0001);
    bus.irq_req = '0;
    tick();

    // T5: eret from ISR, then eret in IDLE is ignored
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("t5 exit pc_sel",   32'(bus.pc_sel), 32'd1);
    check("t5 exit redirect", bus.pc_redirect, 32'h88);
    check("t5 exit flush",    32'(bus.flush), 32'd1);
    tick();
    check("t5 idle in_isr", 32'(bus.in_isr), 32'd0);
    check("t5 idle pc_sel", 32'(bus.pc_sel), 32'd0);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("t5 idle eret pc_sel", 32'(bus.pc_sel), 32'd0);
    check("t5 idle eret flush",  32'(bus.flush), 32'd0);
    tick();
    check("t5 idle eret2 pc_sel", 32'(bus.pc_sel), 32'd0);

    // T6: request during ISR is not nested, then serviced after EXIT
    bus.irq_req = 4'b0100; bus.pc_resume = 32'h200;
    tick();
    tick();
    check("t6 enter cause", 32'(bus.cause), 32'd2);
    bus.irq_req = '0;
    tick();
    bus.irq_req = 4'b0001;
    tick();
    check("t6 isr no nest pc_sel", 32'(bus.pc_sel), 32'd0);
    check("t6 isr no nest in_isr", 32'(bus.in_isr), 32'd1);
    tick();
    check("t6 isr no nest ack", 32'(bus.irq_ack), 32'd0);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("t6 exit pc_sel",   32'(bus.pc_sel), 32'd1);
    check("t6 exit redirect", bus.pc_redirect, 32'h200);
    tick();
    check("t6 idle in_isr", 32'(bus.in_isr), 32'd0);
    check("t6 idle pc_sel", 32'(bus.pc_sel), 32'd0);
    bus.pc_resume = 32'h300;
    tick();
    check("t6 wait pc_sel", 32'(bus.pc_sel), 32'd0);
    tick();
    check("t6 enter pc_sel", 32'(bus.pc_sel), 32'd1);
    check("t6 enter cause",  32'(bus.cause), 32'd0);
    check("t6 enter ack",    32'(bus.irq_ack), 32'b0001);
    check("t6 enter epc",    bus.epc, 32'h300);
    bus.irq_req = '0;
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    tick();

    // Masked-off request withdraws from WAIT back to IDLE
    bus.irq_req = 4'b0010; bus.pipe_ok = 1'b0;
    tick();
    bus.irq_mask = 4'b0000;
    tick();
    bus.pipe_ok = 1'b1;
    tick();
    check("mask withdraw pc_sel", 32'(bus.pc_sel), 32'd0);
    tick();
    check("mask withdraw pc_sel2", 32'(bus.pc_sel), 32'd0);
    check("mask withdraw in_isr",  32'(bus.in_isr), 32'd0);

    // Winner is chosen at the ENTER edge after a mask change in WAIT
    bus.irq_req = 4'b0011; bus.irq_mask = 4'b1111; bus.pipe_ok = 1'b0; bus.pc_resume = 32'h400;
    tick();
    bus.irq_mask = 4'b1110; bus.pipe_ok = 1'b1;
    tick();
    check("remask cause", 32'(bus.cause), 32'd1);
    check("remask ack",   32'(bus.irq_ack), 32'b0010);
    bus.irq_req = '0;
    tick();
    check("remask isr in_isr", 32'(bus.in_isr), 32'd1);

    // T1: asynchronous reset mid-cycle while in ISR
    #2;
    rst_n = 1'b0;
    #1;
    check("t1 pc_sel",   32'(bus.pc_sel), 32'd0);
    check("t1 in_isr",   32'(bus.in_isr), 32'd0);
    check("t1 epc",      bus.epc, 32'd0);
    check("t1 cause",    32'(bus.cause), 32'd0);
    check("t1 redirect", bus.pc_redirect, 32'h4);
    bus.irq_mask = '0; bus.eret = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("t1 post idle in_isr", 32'(bus.in_isr), 32'd0);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("t1 post eret pc_sel", 32'(bus.pc_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
